// File: rtl/hough_frame_ctrl.sv
// Purpose : per-frame sequencer for the lane pipeline; admits one frame into the image FIFO,
//           fires hough/highlight start pulses, counts output pixels, watchdog + frame counter.
// Latency : frame_req -> first fifo write 1 cycle; last output read -> frame_done 1 cycle.
// Backpr. : o_src_full is high unless loading and the image FIFO has room; the output side is
//           paced entirely by the consumer (i_out_rd_en / i_out_empty).
//
// Optional build macro: HOUGH_FRAME_CTRL_AUTO_RESTART_EN
//   defined     -> DONE re-enters LOAD directly (counters/flag cleared), frame_req not needed
//   not defined -> DONE returns to IDLE and the next frame waits for frame_req
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_frame_req           host request to admit one frame (level, sampled in IDLE)
//   i_src_wr_en           upstream pixel strobe        o_src_full      backpressure to upstream
//   o_fifo_wr_en          image FIFO write strobe      i_fifo_full     image FIFO full
//   i_hyst_ready          hysteresis BRAM loaded pulse
//   o_hough_go            hough start pulse            i_hough_done    hough finished
//   o_highlight_go        highlight start pulse
//   i_out_rd_en           consumer read strobe         i_out_empty     output FIFO empty
//   o_frame_done          end-of-frame pulse           o_busy          not IDLE
//   o_state               state encoding               o_frame_count   completed frames (wraps)
//   o_timeout_err         sticky watchdog error
module hough_frame_ctrl #(
  parameter int WIDTH          = 512,
  parameter int HEIGHT         = 288,
  parameter int TIMEOUT_BITS   = 24,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame_req,
  input  logic                      i_src_wr_en,
  output logic                      o_src_full,
  output logic                      o_fifo_wr_en,
  input  logic                      i_fifo_full,
  input  logic                      i_hyst_ready,
  output logic                      o_hough_go,
  input  logic                      i_hough_done,
  output logic                      o_highlight_go,
  input  logic                      i_out_rd_en,
  input  logic                      i_out_empty,
  output logic                      o_frame_done,
  output logic                      o_busy,
  output logic [2:0]                o_state,
  output logic [FRAME_CNT_BITS-1:0] o_frame_count,
  output logic                      o_timeout_err
);

  localparam int IMAGE_SIZE = WIDTH * HEIGHT;
  localparam int CNT_W      = $clog2(IMAGE_SIZE + 1);
  localparam logic [CNT_W-1:0] IMG_SZ   = CNT_W'(IMAGE_SIZE);
  localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_EDGE = 3'd2,
    S_HOUGH     = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_in_cnt;
  logic [CNT_W-1:0]          r_out_cnt;
  logic [TIMEOUT_BITS-1:0]   r_wd_cnt;
  logic                      r_hyst;
  logic                      r_timeout_err;
  logic [FRAME_CNT_BITS-1:0] r_frame_count;
  logic                      r_hough_go;
  logic                      r_highlight_go;
  logic                      r_frame_done;

  logic w_gate_open;
  logic w_fifo_wr;
  logic w_out_rd;
  logic w_wd_expired;

  // Gate stays open only while loading and short of a full image, so the
  // write that completes the frame closes it in the same cycle.
  assign w_gate_open  = (r_state == S_LOAD) && (r_in_cnt < IMG_SZ);
  assign w_fifo_wr    = i_src_wr_en && w_gate_open && !i_fifo_full;
  assign w_out_rd     = (r_state == S_DRAIN) && i_out_rd_en && !i_out_empty;
  assign w_wd_expired = (r_wd_cnt == {TIMEOUT_BITS{1'b1}});

  assign o_fifo_wr_en   = w_fifo_wr;
  assign o_src_full     = i_fifo_full || !w_gate_open;
  assign o_hough_go     = r_hough_go;
  assign o_highlight_go = r_highlight_go;
  assign o_frame_done   = r_frame_done;
  assign o_busy         = (r_state != S_IDLE);
  assign o_state        = r_state;
  assign o_frame_count  = r_frame_count;
  assign o_timeout_err  = r_timeout_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_in_cnt       <= '0;
      r_out_cnt      <= '0;
      r_wd_cnt       <= '0;
      r_hyst         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_frame_count  <= '0;
      r_hough_go     <= 1'b0;
      r_highlight_go <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_hough_go     <= 1'b0;
      r_highlight_go <= 1'b0;
      r_frame_done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_frame_req) begin
            r_state   <= S_LOAD;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wd_cnt  <= '0;
            r_hyst    <= 1'b0;
          end
        end

        S_LOAD: begin
          // Hysteresis may finish before the last pixel is admitted; keep the pulse.
          if (i_hyst_ready) r_hyst <= 1'b1;
          if (w_fifo_wr) begin
            r_in_cnt <= r_in_cnt + CNT_W'(1);
            if (r_in_cnt == IMG_LAST) begin
              r_state  <= S_WAIT_EDGE;
              r_wd_cnt <= '0;
            end
          end
        end

        S_WAIT_EDGE: begin
          if (i_hyst_ready) r_hyst <= 1'b1;
          if (r_hyst || i_hyst_ready) begin
            r_state    <= S_HOUGH;
            r_hough_go <= 1'b1;
            r_wd_cnt   <= '0;
          end else if (w_wd_expired) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
            r_wd_cnt      <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + TIMEOUT_BITS'(1);
          end
        end

        S_HOUGH: begin
          // hough_done is accepted even in the cycle hough_go is still high.
          if (i_hough_done) begin
            r_state        <= S_DRAIN;
            r_highlight_go <= 1'b1;
            r_wd_cnt       <= '0;
          end else if (w_wd_expired) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
            r_wd_cnt      <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + TIMEOUT_BITS'(1);
          end
        end

        S_DRAIN: begin
          if (w_out_rd) begin
            // Every accepted read proves forward progress and rearms the watchdog.
            r_out_cnt <= r_out_cnt + CNT_W'(1);
            r_wd_cnt  <= '0;
            if (r_out_cnt == IMG_LAST) begin
              r_state       <= S_DONE;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + FRAME_CNT_BITS'(1);
            end
          end else if (w_wd_expired) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
            r_wd_cnt      <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + TIMEOUT_BITS'(1);
          end
        end

        S_DONE: begin
`ifdef HOUGH_FRAME_CTRL_AUTO_RESTART_EN
          r_state   <= S_LOAD;
          r_in_cnt  <= '0;
          r_out_cnt <= '0;
          r_wd_cnt  <= '0;
          r_hyst    <= 1'b0;
`else
          r_state <= S_IDLE;
`endif
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hough_frame_ctrl.sv
// Purpose : directed-plus-random bench for hough_frame_ctrl on an 8x4 image, 6-bit watchdog.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : random out_empty / out_rd_en and toggled fifo_full exercise both flow-control sides.
module tb_hough_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int TB = 6;
  localparam int FB = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOUGH = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
`ifdef HOUGH_FRAME_CTRL_AUTO_RESTART_EN
  localparam logic [2:0] ST_AFTER_DONE = ST_LOAD;
`else
  localparam logic [2:0] ST_AFTER_DONE = ST_IDLE;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_req = 1'b0;
  logic          src_wr_en = 1'b0;
  logic          fifo_full = 1'b0;
  logic          hyst_ready = 1'b0;
  logic          hough_done = 1'b0;
  logic          out_rd_en = 1'b0;
  logic          out_empty = 1'b1;
  logic          o_src_full;
  logic          o_fifo_wr_en;
  logic          o_hough_go;
  logic          o_highlight_go;
  logic          o_frame_done;
  logic          o_busy;
  logic [2:0]    o_state;
  logic [FB-1:0] o_frame_count;
  logic          o_timeout_err;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;

  hough_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .TIMEOUT_BITS(TB), .FRAME_CNT_BITS(FB)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_frame_req    (frame_req),
    .i_src_wr_en    (src_wr_en),
    .o_src_full     (o_src_full),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .i_fifo_full    (fifo_full),
    .i_hyst_ready   (hyst_ready),
    .o_hough_go     (o_hough_go),
    .i_hough_done   (hough_done),
    .o_highlight_go (o_highlight_go),
    .i_out_rd_en    (out_rd_en),
    .i_out_empty    (out_empty),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy),
    .o_state        (o_state),
    .o_frame_count  (o_frame_count),
    .o_timeout_err  (o_timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, o_state, ST_IDLE);
    chk({tag, "_src_full"}, o_src_full, 1);
    chk({tag, "_fifo_wr"}, o_fifo_wr_en, 0);
    chk({tag, "_hough_go"}, o_hough_go, 0);
    chk({tag, "_highlight_go"}, o_highlight_go, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_frame_count"}, o_frame_count, 0);
    chk({tag, "_timeout_err"}, o_timeout_err, 0);
  endtask

  // One cycle with frame_req high; no pixels are offered in this cycle.
  task automatic start_frame();
    frame_req = 1'b1;
    src_wr_en = 1'b0;
    sample();
    chk("start_fifo_wr", o_fifo_wr_en, 0);
    next_cycle();
    frame_req = 1'b0;
  endtask

  // Offers a pixel every cycle; the model admits one whenever the FIFO is not
  // full and fewer than N pixels have gone in. Optionally pulses hyst_ready
  // together with the N-th admitted pixel.
  task automatic load_frame(input bit toggle, input bit hyst_last, input int iters);
    int n = 0;
    int seen = 0;
    int k = -1;
    bit full;
    bit exp_wr;
    for (int i = 0; i < iters; i++) begin
      full       = toggle ? i[0] : 1'b0;
      exp_wr     = !full && (n < N);
      src_wr_en  = 1'b1;
      fifo_full  = full;
      hyst_ready = hyst_last && exp_wr && (n == N - 1);
      sample();
      chk("load_wr_en", o_fifo_wr_en, exp_wr);
      chk("load_src_full", o_src_full, full || (n >= N));
      chk("load_busy", o_busy, 1);
      if (k >= 0 && i == k + 1) chk("load_state_wait", o_state, ST_WAIT);
      seen += int'(o_fifo_wr_en);
      if (exp_wr) begin
        n++;
        if (n == N) k = i;
      end
      next_cycle();
    end
    src_wr_en  = 1'b0;
    fifo_full  = 1'b0;
    hyst_ready = 1'b0;
    chk("load_writes", seen, N);
  endtask

  task automatic pulse_hyst();
    hyst_ready = 1'b1;
    sample();
    chk("hyst_state_wait", o_state, ST_WAIT);
    chk("hyst_hough_go_early", o_hough_go, 0);
    next_cycle();
    hyst_ready = 1'b0;
  endtask

  // Starts at the first HOUGH cycle; hough_done goes high 'delay' cycles after hough_go.
  task automatic hough_phase(input int delay);
    for (int j = 0; j <= delay; j++) begin
      hough_done = (j == delay);
      sample();
      chk("hough_go", o_hough_go, (j == 0));
      chk("hough_state", o_state, ST_HOUGH);
      chk("hough_highlight", o_highlight_go, 0);
      next_cycle();
    end
    hough_done = 1'b0;
  endtask

  // Random consumer; stops after nreads accepted reads. When complete, checks the
  // DONE cycle and the state after it.
  task automatic drain_phase(input int nreads, input bit complete);
    int got = 0;
    int cyc = 0;
    bit rd;
    bit emp;
    while (got < nreads && cyc < 600) begin
      rd        = ($urandom_range(0, 3) != 0);
      emp       = ($urandom_range(0, 2) == 0);
      out_rd_en = rd;
      out_empty = emp;
      sample();
      chk("drain_highlight_go", o_highlight_go, (cyc == 0));
      chk("drain_state", o_state, ST_DRAIN);
      chk("drain_frame_done", o_frame_done, 0);
      if (rd && !emp) got++;
      cyc++;
      next_cycle();
    end
    out_rd_en = 1'b0;
    out_empty = 1'b1;
    chk("drain_reads", got, nreads);
    if (complete) begin
      exp_frames++;
      sample();
      chk("done_pulse", o_frame_done, 1);
      chk("done_state", o_state, ST_DONE);
      next_cycle();
      sample();
      chk("after_done_pulse", o_frame_done, 0);
      chk("after_done_state", o_state, ST_AFTER_DONE);
      chk("after_done_count", o_frame_count, exp_frames);
      next_cycle();
    end
  endtask

  initial begin
    // Reset values.
    sample();
    check_reset_outputs("reset");
    next_cycle();
    rst_n = 1'b1;
    sample();
    chk("idle_hold_state", o_state, ST_IDLE);
    next_cycle();

    // Frame 1: 40 continuous offers, hyst arrives in WAIT_EDGE, hough_done 10 cycles late.
    start_frame();
    load_frame(1'b0, 1'b0, 40);
    sample();
    chk("f1_state_wait", o_state, ST_WAIT);
    next_cycle();
    pulse_hyst();
    hough_phase(10);
    drain_phase(N, 1'b1);

    // Frame 2: fifo_full toggles, hyst on the last write, hough never finishes -> watchdog.
    start_frame();
    load_frame(1'b1, 1'b1, 2 * N);
    for (int j = 0; j < 70; j++) begin
      sample();
      if (j == 0) chk("to_hough_go", o_hough_go, 1);
      chk("to_no_frame_done", o_frame_done, 0);
      if (j == 59) begin
        chk("to_still_hough", o_state, ST_HOUGH);
        chk("to_not_yet", o_timeout_err, 0);
      end
      next_cycle();
    end
    sample();
    chk("to_err", o_timeout_err, 1);
    chk("to_state_idle", o_state, ST_IDLE);
    chk("to_busy", o_busy, 0);
    chk("to_count_kept", o_frame_count, exp_frames);
    next_cycle();

    // Frame 3: hough_done coincides with hough_go; timeout_err stays sticky.
    start_frame();
    load_frame(1'b0, 1'b1, N + 1);
    hough_phase(0);
    drain_phase(N, 1'b1);
    sample();
    chk("sticky_timeout", o_timeout_err, 1);
    next_cycle();

    // Frame 4: reset asserted in the middle of DRAIN.
    start_frame();
    load_frame(1'b0, 1'b1, N + 1);
    hough_phase(3);
    drain_phase(10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    next_cycle();
    rst_n = 1'b1;
    exp_frames = 0;

    // Frames 5 and 6 back to back after reset.
    start_frame();
    load_frame(1'b0, 1'b1, N + 1);
    hough_phase(2);
    drain_phase(N, 1'b1);
    start_frame();
    load_frame(1'b1, 1'b1, 2 * N);
    hough_phase(5);
    drain_phase(N, 1'b1);
    sample();
    chk("final_count", o_frame_count, 2);
    chk("final_timeout_clear", o_timeout_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hough_frame_ctrl.md
Name: hough_frame_ctrl

Overview:
- Per-frame sequencer for the lane-detection pipeline: grayscale -> sobel -> NMS -> hysteresis -> hysteresis BRAM -> hough -> highlight -> output FIFO.
- Gates pixel entry into the image FIFO so exactly one frame is admitted at a time.
- Issues the hough and highlight start pulses, and counts output pixels to detect frame completion.
- Provides a watchdog and a frame counter for the host side.

Parameters:
- WIDTH, 512, image width in pixels
- HEIGHT, 288, image height in pixels
- TIMEOUT_BITS, 24, watchdog counter width; timeout fires at 2^TIMEOUT_BITS-1 idle cycles
- FRAME_CNT_BITS, 16, frame counter width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_req  in  1  host request to admit one frame (level, sampled in IDLE)
- src_wr_en  in  1  upstream pixel write strobe
- src_full  out  1  backpressure to upstream
- fifo_wr_en  out  1  write strobe to image FIFO
- fifo_full  in  1  image FIFO full
- hyst_ready  in  1  single-cycle pulse from hysteresis: BRAM loaded
- hough_go  out  1  single-cycle start pulse to hough
- hough_done  in  1  hough finished (pulse or level)
- highlight_go  out  1  single-cycle start pulse to highlight
- out_rd_en  in  1  consumer read strobe on output FIFO
- out_empty  in  1  output FIFO empty
- frame_done  out  1  single-cycle pulse at end of frame
- busy  out  1  high in any state except IDLE
- state_o  out  3  current state encoding
- frame_count  out  FRAME_CNT_BITS  completed frames, wraps
- timeout_err  out  1  sticky watchdog error

Behaviour:
- IMAGE_SIZE = WIDTH*HEIGHT. Pixel counters are $clog2(IMAGE_SIZE+1) bits, unsigned.
- Reset (reset=0, async): state=IDLE; counters, hyst flag and timeout_err cleared; hough_go=highlight_go=frame_done=0; src_full=1; fifo_wr_en=0.
- States and encodings: IDLE=0, LOAD=1, WAIT_EDGE=2, HOUGH=3, DRAIN=4, DONE=5.
- Gating (combinational):
  - gate_open = (state==LOAD) && (in_cnt < IMAGE_SIZE)
  - fifo_wr_en = src_wr_en && gate_open && !fifo_full
  - src_full = fifo_full || !gate_open
- IDLE: frame_req=1 -> LOAD next cycle; in_cnt, out_cnt, wd_cnt and hyst flag cleared.
- LOAD: in_cnt increments on each fifo_wr_en. On the write that makes in_cnt==IMAGE_SIZE, go to WAIT_EDGE next cycle; extra src_wr_en in that cycle is refused.
- hyst flag: set by hyst_ready in LOAD or WAIT_EDGE, so a pulse arriving before the gate closes is not lost. hyst_ready in any other state is ignored.
- WAIT_EDGE: when the flag is set (or hyst_ready is high this cycle), go to HOUGH. hough_go is registered, high for exactly the first cycle in HOUGH.
- HOUGH: hough_done=1 -> DRAIN. highlight_go is high for exactly the first cycle in DRAIN. hough_done in the same cycle as hough_go is accepted.
- DRAIN: out_cnt increments on out_rd_en && !out_empty. On the read that makes out_cnt==IMAGE_SIZE, go to DONE.
- DONE: frame_done=1 for this single cycle; frame_count += 1 (wraps); -> IDLE.
- Watchdog:
  - wd_cnt counts in WAIT_EDGE, HOUGH and DRAIN.
  - Cleared on every state change and on each counted output read.
  - On reaching all-ones: timeout_err=1 (sticky until reset), state -> IDLE, frame_count unchanged, no frame_done.
  - LOAD has no watchdog; the host controls input pacing.
- Latency: frame_req to first possible fifo_wr_en is 1 cycle; last output read to frame_done is 1 cycle.
- Asynchronous reset mid-frame returns to IDLE immediately. Downstream FIFOs are reset by the same reset; no flush handshake.

Optional Feature:
- Macro: HOUGH_FRAME_CTRL_AUTO_RESTART_EN.
- Defined: DONE goes directly to LOAD, with counters and flag cleared, regardless of frame_req; IDLE is entered only after reset or timeout.
- Not defined: DONE -> IDLE, and a new frame needs frame_req=1.

Test Plan (WIDTH=8, HEIGHT=4, IMAGE_SIZE=32, TIMEOUT_BITS=6):
- Reset, then frame_req=1 and 40 continuous src_wr_en -> exactly 32 fifo_wr_en pulses; src_full=1 from the 33rd onward; state_o=2.
- fifo_full toggled every other cycle in LOAD -> fifo_wr_en=0 whenever fifo_full=1; total writes still 32.
- hyst_ready pulsed on the cycle of the 32nd write -> flag latched; hough_go exactly one cycle, two cycles later.
- hough_done asserted 10 cycles after hough_go; then 32 reads with out_empty randomly high -> highlight_go single pulse; frame_done one cycle after the 32nd valid read; frame_count=1.
- Hold hough_done=0 for 70 cycles in HOUGH -> timeout_err=1 at 63 idle cycles; state_o=0; frame_count unchanged.
- Reset driven low mid-DRAIN -> all outputs at reset values within the same cycle. With AUTO_RESTART_EN defined and two frames run -> state_o=1 immediately after frame_done, frame_count=2.
